msp430_sync_debounce: RTL and testbench

MSP430_SYNC_DEBOUNCE -- requirements
Module: msp430_sync_debounce

---
 rtl/msp430_sync_pkg.sv | 13 +
 rtl/msp430_sync_debounce_chan.sv | 62 ++++++
 rtl/msp430_sync_debounce.sv | 35 +++
 tb/tb_msp430_sync_debounce.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/msp430_sync_pkg.sv
// Shared defaults and sizing helpers for the synchronizer/debounce block.
package msp430_sync_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_STAGES   = 2;
    localparam int DEF_FILT_CNT = 3;

    // Counter width able to hold values up to FILT_CNT.
    function automatic int cnt_w(input int filt_cnt);
        return $clog2(filt_cnt + 1);
    endfunction

endpackage

// File: rtl/msp430_sync_debounce_chan.sv
// One channel: metastability chain, stability counter, and registered edge pulses.
module msp430_sync_debounce_chan
    import msp430_sync_pkg::*;
#(
    parameter int   STAGES   = DEF_STAGES,
    parameter int   FILT_CNT = DEF_FILT_CNT,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    input  logic filt_en,
    output logic data_out,
    output logic rise,
    output logic fall
);

    localparam int             CW      = cnt_w(FILT_CNT);
    localparam logic [CW-1:0]  CNT_MAX = CW'(FILT_CNT - 1);

    logic [STAGES-1:0] r_sync;
    logic [CW-1:0]     r_cnt;
    logic              r_out;
    logic              r_rise;
    logic              r_fall;

    logic w_s;
    logic w_diff;
    logic w_take;

    assign w_s    = r_sync[STAGES-1];
    assign w_diff = (w_s != r_out);
    // Bypass behaves as a threshold of one: any difference is taken immediately.
    assign w_take = w_diff && (!filt_en || (r_cnt == CNT_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_BIT}};
            r_out  <= RST_BIT;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], data_in};
            r_rise <= w_take &&  w_s;
            r_fall <= w_take && !w_s;
            if (w_take) begin
                r_out <= w_s;
                r_cnt <= '0;
            end else if (w_diff && filt_en) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign data_out = r_out;
    assign rise     = r_rise;
    assign fall     = r_fall;

endmodule

// File: rtl/msp430_sync_debounce.sv
// Multi-channel input synchronizer with optional glitch filter and edge pulses.
module msp430_sync_debounce
    import msp430_sync_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               STAGES   = DEF_STAGES,
    parameter int               FILT_CNT = DEF_FILT_CNT,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             filt_en,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        msp430_sync_debounce_chan #(
            .STAGES   (STAGES),
            .FILT_CNT (FILT_CNT),
            .RST_BIT  (RST_VAL[g])
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .data_in  (data_in[g]),
            .filt_en  (filt_en),
            .data_out (data_out[g]),
            .rise     (rise[g]),
            .fall     (fall[g])
        );
    end

endmodule

// File: tb/tb_msp430_sync_debounce.sv
// Directed and randomized checks of msp430_sync_debounce against a behavioural model.
module tb_msp430_sync_debounce;

    localparam int             W  = 4;
    localparam int             S  = 2;
    localparam int             F  = 3;
    localparam logic [W-1:0]   RV = '0;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         filt_en = 1'b1;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int checks = 0;
    int errors = 0;

    // Model state: delay line of sampled inputs, filtered level, pulses, run lengths.
    logic [W-1:0] m_pipe [S];
    logic [W-1:0] m_out;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    int           m_run  [W];

    msp430_sync_debounce #(
        .WIDTH    (W),
        .STAGES   (S),
        .FILT_CNT (F),
        .RST_VAL  (RV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .filt_en  (filt_en),
        .data_out (data_out),
        .rise     (rise),
        .fall     (fall)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic [W-1:0] s;
        if (rst) begin
            for (int i = 0; i < S; i++) m_pipe[i] = RV;
            for (int c = 0; c < W; c++) m_run[c] = 0;
            m_out  = RV;
            m_rise = '0;
            m_fall = '0;
        end else begin
            s      = m_pipe[S-1];
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < W; c++) begin
                if (s[c] !== m_out[c]) begin
                    m_run[c]++;
                    if (!filt_en || m_run[c] >= F) begin
                        m_out[c] = s[c];
                        m_run[c] = 0;
                        if (s[c]) m_rise[c] = 1'b1;
                        else      m_fall[c] = 1'b1;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (!filt_en) m_run[c] = 0;
            end
            for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
            m_pipe[0] = data_in;
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("data_out", data_out, m_out);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("rise_fall_excl", rise & fall, '0);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Reset with all inputs high; release and expect a 5-edge rise on every channel.
        rst = 1'b1; data_in = 4'hF; filt_en = 1'b1;
        step();
        step();
        check("reset_out", data_out, 4'h0);
        rst = 1'b0;
        step();
        check("no_pulse_after_release", rise | fall, 4'h0);
        steps(3);
        check("pre_release_edge5", data_out, 4'h0);
        step();
        check("release_edge5_out", data_out, 4'hF);
        check("release_edge5_rise", rise, 4'hF);
        step();
        check("release_rise_one_cycle", rise, 4'h0);

        // Return to all low.
        data_in = 4'h0;
        steps(6);
        check("all_low", data_out, 4'h0);

        // Two-cycle glitch is rejected.
        data_in = 4'h1;
        steps(2);
        data_in = 4'h0;
        steps(6);
        check("glitch2_rejected", data_out, 4'h0);

        // Three-cycle pulse passes; fall follows three cycles after rise.
        data_in = 4'h1;
        steps(3);
        data_in = 4'h0;
        steps(2);
        check("pulse3_out", data_out, 4'h1);
        check("pulse3_rise", rise, 4'h1);
        steps(3);
        check("pulse3_fall", fall, 4'h1);
        check("pulse3_low", data_out, 4'h0);
        steps(2);

        // Bypass: one-cycle pulse on channel 1 appears after three edges.
        filt_en = 1'b0;
        data_in = 4'h2;
        step();
        data_in = 4'h0;
        steps(2);
        check("bypass_out", data_out, 4'h2);
        check("bypass_rise", rise, 4'h2);
        step();
        check("bypass_fall", fall, 4'h2);
        check("bypass_low", data_out, 4'h0);
        filt_en = 1'b1;
        steps(3);

        // Reset mid-count on channel 2 discards progress.
        data_in = 4'h4;
        steps(3);
        rst = 1'b1;
        step();
        check("midcount_reset_out", data_out, 4'h0);
        rst = 1'b0;
        steps(4);
        check("midcount_not_yet", data_out, 4'h0);
        check("midcount_no_pulse", rise | fall, 4'h0);
        step();
        check("midcount_full5", data_out, 4'h4);

        // Simultaneous rise and fall on different channels.
        data_in = 4'h8;
        steps(8);
        check("only_ch3", data_out, 4'h8);
        data_in = 4'h4;
        steps(5);
        check("swap_rise", rise, 4'h4);
        check("swap_fall", fall, 4'h8);

        // Randomized traffic, including filter toggles and occasional resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 2) == 0)
                data_in = data_in ^ W'(1 << $urandom_range(0, W - 1));
            if ($urandom_range(0, 39) == 0) filt_en = ~filt_en;
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
